// File: rtl/rapid_mem_arbiter.sv
// Two-port memory arbiter: fetch (port 0) and data (port 1) share one memory controller port.
// One transaction in flight. Data has priority, fetch has a starvation bound, and a watchdog ends stalled waits.

module rapid_mem_arbiter_lane (
  input  logic i_clk,
  input  logic i_reset,
  input  logic fire,
  input  logic sel,
  output logic res_valid
);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) res_valid <= 1'b0;
    else         res_valid <= fire & sel;
  end
endmodule

module rapid_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [1:0]                 i_req_valid,
  input  logic [2*ADDR_W-1:0]        i_req_addr,
  input  logic [1:0]                 i_req_we,
  input  logic [2*DATA_W-1:0]        i_req_wdata,
  input  logic [2*(DATA_W/8)-1:0]    i_req_be,
  output logic [1:0]                 o_req_ready,
  output logic [1:0]                 o_res_valid,
  output logic [DATA_W-1:0]          o_res_data,
  output logic                       o_res_err,
  output logic                       o_mem_req_valid,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic                       o_mem_we,
  output logic [DATA_W-1:0]          o_mem_wdata,
  output logic [DATA_W/8-1:0]        o_mem_be,
  input  logic                       i_mem_req_ready,
  input  logic                       i_mem_res_valid,
  input  logic [DATA_W-1:0]          i_mem_res_data
);
  localparam int BE_W = DATA_W/8;
  localparam logic [3:0]  MAX_B = 4'(MAX_DATA_BURST);
  localparam logic [15:0] TMO   = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                     state;
  logic                       owner;
  logic [3:0]                 starve_cnt;
  logic [15:0]                tmo_cnt;
  logic                       win;
  logic                       res_fire;
  logic [1:0]                 res_sel;
  logic [1:0][ADDR_W-1:0]     req_addr;
  logic [1:0][DATA_W-1:0]     req_wdata;
  logic [1:0][BE_W-1:0]       req_be;

  for (genvar p = 0; p < 2; p++) begin : g_lane
    assign req_addr[p]  = i_req_addr[p*ADDR_W +: ADDR_W];
    assign req_wdata[p] = i_req_wdata[p*DATA_W +: DATA_W];
    assign req_be[p]    = i_req_be[p*BE_W +: BE_W];
    assign res_sel[p]   = (owner == 1'(p));

    rapid_mem_arbiter_lane u_lane (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .fire      (res_fire),
      .sel       (res_sel[p]),
      .res_valid (o_res_valid[p])
    );
  end

  // Data wins a contest unless fetch has already waited out a full burst.
  always_comb begin
    win = i_req_valid[1] && !(i_req_valid[0] && starve_cnt == MAX_B);
    o_req_ready = 2'b00;
    if (state == IDLE && !i_reset && |i_req_valid)
      o_req_ready = win ? 2'b10 : 2'b01;
  end

  // A response sampled on the final watchdog cycle is still a normal response.
  always_comb begin
    res_fire = 1'b0;
    if (state == WAIT && (i_mem_res_valid || tmo_cnt + 16'd1 == TMO))
      res_fire = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      owner           <= 1'b0;
      starve_cnt      <= '0;
      tmo_cnt         <= '0;
      o_res_data      <= '0;
      o_res_err       <= 1'b0;
      o_mem_req_valid <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_we        <= 1'b0;
      o_mem_wdata     <= '0;
      o_mem_be        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_req_valid) begin
            owner           <= win;
            o_mem_addr      <= req_addr[win];
            o_mem_we        <= i_req_we[win];
            o_mem_wdata     <= req_wdata[win];
            o_mem_be        <= req_be[win];
            o_mem_req_valid <= 1'b1;
            state           <= ISSUE;
            if (win && i_req_valid[0])
              starve_cnt <= (starve_cnt == MAX_B) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (i_mem_req_ready) begin
            o_mem_req_valid <= 1'b0;
            tmo_cnt         <= '0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_res_valid) begin
            o_res_data <= i_mem_res_data;
            o_res_err  <= 1'b0;
            state      <= IDLE;
          end else if (tmo_cnt + 16'd1 == TMO) begin
            o_res_data <= '0;
            o_res_err  <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rapid_mem_arbiter.sv
// Directed bench for rapid_mem_arbiter with MAX_DATA_BURST=4 and TIMEOUT=8.
module tb_rapid_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW/8;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [1:0]      i_req_valid;
  logic [2*AW-1:0] i_req_addr;
  logic [1:0]      i_req_we;
  logic [2*DW-1:0] i_req_wdata;
  logic [2*BW-1:0] i_req_be;
  logic [1:0]      o_req_ready;
  logic [1:0]      o_res_valid;
  logic [DW-1:0]   o_res_data;
  logic            o_res_err;
  logic            o_mem_req_valid;
  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_we;
  logic [DW-1:0]   o_mem_wdata;
  logic [BW-1:0]   o_mem_be;
  logic            i_mem_req_ready;
  logic            i_mem_res_valid;
  logic [DW-1:0]   i_mem_res_data;

  int checks = 0;
  int errors = 0;
  int exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  rapid_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(4), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_we(i_req_we),
    .i_req_wdata(i_req_wdata), .i_req_be(i_req_be), .o_req_ready(o_req_ready),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_err(o_res_err),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_req_ready(i_mem_req_ready),
    .i_mem_res_valid(i_mem_res_valid), .i_mem_res_data(i_mem_res_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be);
    i_req_addr[p*AW +: AW]  = a;
    i_req_we[p]             = we;
    i_req_wdata[p*DW +: DW] = wd;
    i_req_be[p*BW +: BW]    = be;
    i_req_valid[p]          = 1'b1;
  endtask

  initial begin
    i_reset = 1'b1; i_req_valid = '0; i_req_addr = '0; i_req_we = '0;
    i_req_wdata = '0; i_req_be = '0; i_mem_req_ready = 1'b0;
    i_mem_res_valid = 1'b0; i_mem_res_data = '0;

    // Reset: outputs zero even with requests pending
    step(); i_req_valid = 2'b11; #1;
    chk("rst_ctl", 64'({o_req_ready, o_res_valid, o_res_err, o_mem_req_valid, o_mem_we, o_mem_be}), 64'(0));
    chk("rst_data", 64'({o_res_data, o_mem_addr}), 64'(0));
    chk("rst_wdata", 64'(o_mem_wdata), 64'(0));
    i_req_valid = 2'b00;
    step(); i_reset = 1'b0;
    step();

    // Single fetch, 3-cycle latency
    set_req(0, 32'h100, 1'b0, 32'h0, 4'hF); #1;
    chk("t1_ready", 64'(o_req_ready), 64'(2'b01));
    step(); i_req_valid = 2'b00; i_mem_req_ready = 1'b1; #1;
    chk("t1_issue", 64'({o_mem_req_valid, o_mem_we, o_mem_addr}), 64'({1'b1, 1'b0, 32'h100}));
    chk("t1_no_ready", 64'(o_req_ready), 64'(2'b00));
    step(); i_mem_req_ready = 1'b0; i_mem_res_valid = 1'b1; i_mem_res_data = 32'hDEADBEEF; #1;
    chk("t1_wait", 64'({o_res_valid, o_mem_req_valid}), 64'(0));
    step(); i_mem_res_valid = 1'b0; #1;
    chk("t1_res", 64'({o_res_valid, o_res_err, o_res_data}), 64'({2'b01, 1'b0, 32'hDEADBEEF}));

    // Priority and starvation: both ports continuously requesting
    set_req(0, 32'h1000, 1'b0, 32'h0, 4'hF);
    set_req(1, 32'h2000, 1'b0, 32'h0, 4'hF);
    i_mem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("grant", 64'(o_req_ready), exp_g[k] != 0 ? 64'(2'b10) : 64'(2'b01));
      if (k > 0) chk("route", 64'(o_res_valid), exp_g[k-1] != 0 ? 64'(2'b10) : 64'(2'b01));
      step(); step();
      i_mem_res_valid = 1'b1; i_mem_res_data = 32'(k);
      step(); i_mem_res_valid = 1'b0;
    end
    #1;
    chk("route_last", 64'(o_res_valid), 64'(2'b01));
    chk("starve_clr", 64'(o_req_ready), 64'(2'b10));
    i_req_valid = 2'b00; i_mem_req_ready = 1'b0;
    step();

    // Backpressure on a data write
    set_req(1, 32'h40, 1'b1, 32'hA5A5A5A5, 4'b0011); #1;
    chk("bp_ready", 64'(o_req_ready), 64'(2'b10));
    step(); i_req_valid = 2'b00;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) i_mem_req_ready = 1'b1;
      #1;
      chk("bp_fields", 64'({o_mem_req_valid, o_mem_we, o_mem_be, o_mem_addr}), 64'({1'b1, 1'b1, 4'b0011, 32'h40}));
      chk("bp_wdata", 64'(o_mem_wdata), 64'(32'hA5A5A5A5));
      step();
    end
    i_mem_req_ready = 1'b0; #1;
    chk("bp_one_hs", 64'(o_mem_req_valid), 64'(0));
    i_mem_res_valid = 1'b1; i_mem_res_data = 32'h11112222;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("bp_res", 64'({o_res_valid, o_res_err, o_res_data}), 64'({2'b10, 1'b0, 32'h11112222}));

    // Timeout after 8 WAIT cycles
    set_req(0, 32'h200, 1'b0, 32'h0, 4'hF); #1;
    chk("tmo_ready", 64'(o_req_ready), 64'(2'b01));
    step(); i_req_valid = 2'b00; i_mem_req_ready = 1'b1;
    step(); i_mem_req_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1; chk("tmo_wait", 64'(o_res_valid), 64'(0));
      step();
    end
    #1;
    chk("tmo_res", 64'({o_res_valid, o_res_err, o_res_data}), 64'({2'b01, 1'b1, 32'h0}));
    step(); step();
    i_mem_res_valid = 1'b1; i_mem_res_data = 32'hBAD0BAD0; #1;
    chk("late_idle", 64'(o_res_valid), 64'(0));
    step(); i_mem_res_valid = 1'b0; #1;
    chk("late_drop", 64'(o_res_valid), 64'(0));
    set_req(1, 32'h300, 1'b0, 32'h0, 4'hF); #1;
    chk("post_tmo_ready", 64'(o_req_ready), 64'(2'b10));
    step(); i_req_valid = 2'b00; i_mem_req_ready = 1'b1;
    step(); i_mem_req_ready = 1'b0; i_mem_res_valid = 1'b1; i_mem_res_data = 32'h12345678;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("post_tmo_res", 64'({o_res_valid, o_res_err, o_res_data}), 64'({2'b10, 1'b0, 32'h12345678}));

    // Response in the final watchdog cycle is a normal response
    set_req(0, 32'h204, 1'b0, 32'h0, 4'hF);
    step(); i_req_valid = 2'b00; i_mem_req_ready = 1'b1;
    step(); i_mem_req_ready = 1'b0;
    for (int c = 0; c < 7; c++) step();
    i_mem_res_valid = 1'b1; i_mem_res_data = 32'hCAFEF00D;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("edge_res", 64'({o_res_valid, o_res_err, o_res_data}), 64'({2'b01, 1'b0, 32'hCAFEF00D}));

    // Reset while in WAIT
    set_req(1, 32'h500, 1'b1, 32'h77, 4'hF);
    step(); i_req_valid = 2'b00; i_mem_req_ready = 1'b1;
    step(); i_mem_req_ready = 1'b0; #1;
    chk("pre_rst_addr", 64'(o_mem_addr), 64'(32'h500));
    i_reset = 1'b1; i_req_valid = 2'b11; #1;
    chk("mid_rst_ctl", 64'({o_req_ready, o_res_valid, o_res_err, o_mem_req_valid, o_mem_we, o_mem_be}), 64'(0));
    chk("mid_rst_data", 64'({o_res_data, o_mem_addr}), 64'(0));
    i_req_valid = 2'b00;
    step(); i_reset = 1'b0; i_mem_res_valid = 1'b1; i_mem_res_data = 32'h99;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("rst_drop", 64'(o_res_valid), 64'(0));

    // Stray responses in IDLE and ISSUE
    i_mem_res_valid = 1'b1;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("stray_idle", 64'(o_res_valid), 64'(0));
    set_req(0, 32'h600, 1'b0, 32'h0, 4'hF); #1;
    chk("stray_still_idle", 64'(o_req_ready), 64'(2'b01));
    step(); i_req_valid = 2'b00; i_mem_res_valid = 1'b1;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("stray_issue", 64'({o_res_valid, o_mem_req_valid}), 64'({2'b00, 1'b1}));
    i_mem_req_ready = 1'b1;
    step(); i_mem_req_ready = 1'b0; i_mem_res_valid = 1'b1; i_mem_res_data = 32'h600D;
    step(); i_mem_res_valid = 1'b0; #1;
    chk("stray_res", 64'({o_res_valid, o_res_err, o_res_data}), 64'({2'b01, 1'b0, 32'h600D}));

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
